// File: rtl/nios_event_capture_pio.sv
// nios_event_capture_pio
//
// Avalon-MM input PIO with per-bit edge capture, interrupt masking and a
// saturating per-cycle event counter. Four-word slave:
//   0 DATA    (RO)  synchronised in_port
//   1 IRQMASK (RW)  WIDTH bits
//   2 EDGECAP (R/W-clear) WIDTH bits
//   3 EVCOUNT (R, any write clears) CNT_WIDTH bits
//
// Optional feature macro: EVENT_PIO_BITCLR_EN
//   defined   - a write to EDGECAP clears only the bits set in writedata
//   undefined - any write to EDGECAP clears every bit
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   address_i    word address
//   chipselect_i slave select
//   write_n_i    active-low write strobe
//   writedata_i  write data
//   in_port_i    asynchronous event inputs
//   readdata_o   registered read data (1-cycle latency)
//   irq_o        interrupt request, |(EDGECAP & IRQMASK)

module nios_event_capture_pio #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [31:0]      readdata_o,
    output logic             irq_o
);

    localparam logic [2:0] GuardMax = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     prev_q;
    logic [2:0]           guard_q;
    logic [WIDTH-1:0]     irqmask_q, irqmask_d;
    logic [WIDTH-1:0]     edgecap_q, edgecap_d;
    logic [CNT_WIDTH-1:0] evcount_q, evcount_d;
    logic [31:0]          readdata_d;

    logic [WIDTH-1:0]     sync_out;
    logic [WIDTH-1:0]     edge_raw;
    logic [WIDTH-1:0]     edge_vec;
    logic [WIDTH-1:0]     clr_mask;
    logic                 guard_done;
    logic                 any_event;
    logic                 wr_en;
    logic                 unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign guard_done   = (guard_q == GuardMax);
    assign wr_en        = chipselect_i & ~write_n_i;
    assign unused_wdata = ^writedata_i;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_raw = sync_out & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~sync_out & prev_q;
        end else begin
            edge_raw = sync_out ^ prev_q;
        end
    end

    // Suppress edges until the chain and prev have filled, so levels present
    // at reset release are never reported.
    assign edge_vec  = guard_done ? edge_raw : '0;
    assign any_event = |edge_vec;

`ifdef EVENT_PIO_BITCLR_EN
    assign clr_mask = writedata_i[WIDTH-1:0];
`else
    assign clr_mask = {WIDTH{1'b1}};
`endif

    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && address_i == 2'd1) begin
            irqmask_d = writedata_i[WIDTH-1:0];
        end
    end

    // Set wins over a same-cycle clear.
    always_comb begin
        edgecap_d = edgecap_q;
        if (wr_en && address_i == 2'd2) begin
            edgecap_d = edgecap_q & ~clr_mask;
        end
        edgecap_d = edgecap_d | edge_vec;
    end

    always_comb begin
        evcount_d = evcount_q;
        if (wr_en && address_i == 2'd3) begin
            evcount_d = any_event ? CNT_WIDTH'(1) : '0;
        end else if (any_event && !(&evcount_q)) begin
            evcount_d = evcount_q + 1'b1;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address_i)
            2'd0:    readdata_d[WIDTH-1:0]     = sync_out;
            2'd1:    readdata_d[WIDTH-1:0]     = irqmask_q;
            2'd2:    readdata_d[WIDTH-1:0]     = edgecap_q;
            default: readdata_d[CNT_WIDTH-1:0] = evcount_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            guard_q    <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            evcount_q  <= '0;
            readdata_o <= '0;
        end else begin
            sync_q[0] <= in_port_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_out;
            if (!guard_done) begin
                guard_q <= guard_q + 3'd1;
            end
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            evcount_q  <= evcount_d;
            readdata_o <= readdata_d;
        end
    end

    assign irq_o = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_event_capture_pio.sv
module tb_nios_event_capture_pio;

`ifdef EVENT_PIO_BITCLR_EN
    localparam bit BitClr = 1'b1;
`else
    localparam bit BitClr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [2:0]  in_a = '0;
    logic [2:0]  in_b = '0;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Default build: rising edge, 16-bit counter.
    nios_event_capture_pio #(
        .WIDTH(3), .EDGE_TYPE(0), .SYNC_STAGES(2), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address_i(address), .chipselect_i(chipselect),
        .write_n_i(write_n), .writedata_i(writedata), .in_port_i(in_a),
        .readdata_o(rd_a), .irq_o(irq_a)
    );

    // Any-edge, 4-bit counter for saturation tests.
    nios_event_capture_pio #(
        .WIDTH(3), .EDGE_TYPE(2), .SYNC_STAGES(2), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address_i(address), .chipselect_i(chipselect),
        .write_n_i(write_n), .writedata_i(writedata), .in_port_i(in_b),
        .readdata_o(rd_b), .irq_o(irq_b)
    );

    typedef struct {
        logic [2:0]  in;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] addr, input logic wr, input logic [31:0] wdata);
        address    = addr;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each vector: inputs applied before edge k, checks taken just after it.
        // readdata reflects state before edge k; irq reflects state after it.
        vecs.push_back('{3'b111, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0}); // e1
        vecs.push_back('{3'b111, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0}); // e2
        vecs.push_back('{3'b111, 2'd0, 1'b0, 32'h0, 32'h7, 1'b0}); // e3 sync full, guard blocks
        vecs.push_back('{3'b111, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0}); // e4 no startup edge
        vecs.push_back('{3'b111, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0}); // e5 count 0
        vecs.push_back('{3'b111, 2'd1, 1'b1, 32'h2, 32'h0, 1'b0}); // e6 mask=2
        vecs.push_back('{3'b000, 2'd1, 1'b0, 32'h0, 32'h2, 1'b0}); // e7
        vecs.push_back('{3'b000, 2'd0, 1'b0, 32'h0, 32'h7, 1'b0}); // e8
        vecs.push_back('{3'b010, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0}); // e9 pulse bit1
        vecs.push_back('{3'b000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0}); // e10
        vecs.push_back('{3'b000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1}); // e11 captured
        vecs.push_back('{3'b000, 2'd2, 1'b0, 32'h0, 32'h2, 1'b1}); // e12
        vecs.push_back('{3'b000, 2'd3, 1'b0, 32'h0, 32'h1, 1'b1}); // e13 count 1
        vecs.push_back('{3'b000, 2'd2, 1'b1, 32'h2, 32'h2, 1'b0}); // e14 clear
        vecs.push_back('{3'b000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0}); // e15
        vecs.push_back('{3'b000, 2'd1, 1'b1, 32'h0, 32'h2, 1'b0}); // e16 mask=0
        vecs.push_back('{3'b101, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0}); // e17 rise bits 0,2
        vecs.push_back('{3'b101, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0}); // e18
        vecs.push_back('{3'b101, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0}); // e19 captured, masked
        vecs.push_back('{3'b101, 2'd2, 1'b0, 32'h0, 32'h5, 1'b0}); // e20
        vecs.push_back('{3'b101, 2'd2, 1'b1, 32'h1, 32'h5, 1'b0}); // e21 clear bit0 write
        vecs.push_back('{3'b101, 2'd2, 1'b0, 32'h0, BitClr ? 32'h4 : 32'h0, 1'b0}); // e22
        vecs.push_back('{3'b101, 2'd3, 1'b0, 32'h0, 32'h2, 1'b0}); // e23 count 2
        vecs.push_back('{3'b100, 2'd1, 1'b1, 32'h1, 32'h0, 1'b0}); // e24 mask=1, bit0 low
        vecs.push_back('{3'b100, 2'd1, 1'b0, 32'h0, 32'h1, 1'b0}); // e25
        vecs.push_back('{3'b101, 2'd1, 1'b0, 32'h0, 32'h1, 1'b0}); // e26 bit0 rises
        vecs.push_back('{3'b101, 2'd0, 1'b0, 32'h0, 32'h4, 1'b0}); // e27
        vecs.push_back('{3'b101, 2'd2, 1'b1, 32'h1, BitClr ? 32'h4 : 32'h0, 1'b1}); // e28 collision
        vecs.push_back('{3'b101, 2'd2, 1'b0, 32'h0, BitClr ? 32'h5 : 32'h1, 1'b1}); // e29
        vecs.push_back('{3'b101, 2'd3, 1'b0, 32'h0, 32'h3, 1'b1}); // e30 count 3

        // Reset with inputs high.
        in_a = 3'b111;
        drive(2'd0, 1'b0, 32'h0);
        tick();
        tick();
        check("reset_rd", rd_a, 32'h0);
        check("reset_irq", {31'h0, irq_a}, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            in_a = vecs[i].in;
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            tick();
            check($sformatf("vec%0d_rd", i + 1), rd_a, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i + 1), {31'h0, irq_a}, {31'h0, vecs[i].exp_irq});
        end

        // Saturation on the any-edge instance: 20 toggles, 4-bit counter.
        drive(2'd0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            in_b[0] = ~in_b[0];
            tick();
        end
        tick();
        tick();
        tick();
        drive(2'd3, 1'b0, 32'h0);
        tick();
        check("sat_count", rd_b, 32'd15);
        tick();
        check("sat_hold", rd_b, 32'd15);

        // Clear and event in the same cycle: toggle at edge A, event captured at A+2.
        in_b[0] = ~in_b[0];
        tick();                     // A
        tick();                     // A+1
        drive(2'd3, 1'b1, 32'h0);
        tick();                     // A+2: clear + event
        drive(2'd3, 1'b0, 32'h0);
        tick();                     // A+3
        check("clr_event_count", rd_b, 32'd1);

        // Asynchronous reset mid-operation (dut_a has irq asserted).
        check("pre_reset_irq", {31'h0, irq_a}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_irq", {31'h0, irq_a}, 32'h0);
        check("midreset_rd", rd_a, 32'h0);
        check("midreset_rd_b", rd_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
